// File: rtl/alarm_settings_ctrl_if.sv
// rtl/alarm_settings_ctrl_if.sv - button inputs and alarm-load outputs of the alarm settings controller
interface alarm_settings_ctrl_if #(
    parameter int IW = 1,
    parameter int HW = 6,
    parameter int MW = 7
);
    logic          btn_mode;
    logic          btn_inc;
    logic          btn_dec;
    logic          btn_sel;
    logic          set_alarm;
    logic [IW-1:0] set_index;
    logic [HW-1:0] set_hours;
    logic [MW-1:0] set_minutes;
    logic          editing;
    logic          edit_field;
    logic          boot_done;

    modport master (
        output btn_mode, btn_inc, btn_dec, btn_sel,
        input  set_alarm, set_index, set_hours, set_minutes, editing, edit_field, boot_done
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, btn_sel,
        output set_alarm, set_index, set_hours, set_minutes, editing, edit_field, boot_done
    );
endinterface

// File: rtl/alarm_settings_ctrl.sv
// rtl/alarm_settings_ctrl.sv - alarm slot storage with boot load and button-driven hour/minute editing
module alarm_settings_ctrl #(
    parameter int NUM_ALARMS  = 2,
    parameter int HOURS_MAX   = 24,
    parameter int MINUTES_MAX = 60,
    parameter int DEF_HOURS   = 2,
    parameter int DEF_MINUTES = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    alarm_settings_ctrl_if.slave bus
);
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int HW = $clog2(HOURS_MAX) + 1;
    localparam int MW = $clog2(MINUTES_MAX) + 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ALARMS - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HOURS_MAX - 1);
    localparam logic [MW-1:0] M_LAST   = MW'(MINUTES_MAX - 1);
    localparam logic [HW-1:0] DEF_H    = HW'(DEF_HOURS);
    localparam logic [MW-1:0] DEF_M    = MW'(DEF_MINUTES);

    if (DEF_HOURS >= HOURS_MAX || DEF_MINUTES >= MINUTES_MAX) begin : g_bad_default
        $error("alarm_settings_ctrl: default time outside hour/minute modulus");
    end
    if (NUM_ALARMS < 1 || NUM_ALARMS > 16) begin : g_bad_slots
        $error("alarm_settings_ctrl: NUM_ALARMS must be 1..16");
    end

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_EDIT_H,
        S_EDIT_M,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] boot_cnt_q, boot_cnt_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [HW-1:0] edit_h_q, edit_h_d;
    logic [MW-1:0] edit_m_q, edit_m_d;
    logic [HW-1:0] slot_h_q [NUM_ALARMS];
    logic [HW-1:0] slot_h_d [NUM_ALARMS];
    logic [MW-1:0] slot_m_q [NUM_ALARMS];
    logic [MW-1:0] slot_m_d [NUM_ALARMS];

    logic          set_alarm_q, set_alarm_d;
    logic [IW-1:0] set_index_q, set_index_d;
    logic [HW-1:0] set_hours_q, set_hours_d;
    logic [MW-1:0] set_minutes_q, set_minutes_d;
    logic          editing_q, editing_d;
    logic          edit_field_q, edit_field_d;
    logic          boot_done_q, boot_done_d;

    logic          step;
    logic          up;

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        sel_d      = sel_q;
        edit_h_d   = edit_h_q;
        edit_m_d   = edit_m_q;
        slot_h_d   = slot_h_q;
        slot_m_d   = slot_m_q;
        // Pressing inc and dec together cancels out.
        step       = bus.btn_inc ^ bus.btn_dec;
        up         = bus.btn_inc;

        case (state_q)
            S_BOOT: begin
                boot_cnt_d = boot_cnt_q + IW'(1);
                if (boot_cnt_q == IDX_LAST) begin
                    boot_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.btn_sel) begin
                    sel_d = (sel_q == IDX_LAST) ? '0 : sel_q + IW'(1);
                end else if (bus.btn_mode) begin
                    edit_h_d = slot_h_q[sel_q];
                    edit_m_d = slot_m_q[sel_q];
                    state_d  = S_EDIT_H;
                end
            end
            S_EDIT_H: begin
                if (bus.btn_sel) begin
                    state_d = S_IDLE;
                end else if (bus.btn_mode) begin
                    state_d = S_EDIT_M;
                end else if (step) begin
                    if (up) edit_h_d = (edit_h_q == H_LAST) ? '0 : edit_h_q + HW'(1);
                    else    edit_h_d = (edit_h_q == '0) ? H_LAST : edit_h_q - HW'(1);
                end
            end
            S_EDIT_M: begin
                if (bus.btn_sel) begin
                    state_d = S_IDLE;
                end else if (bus.btn_mode) begin
                    state_d = S_COMMIT;
                end else if (step) begin
                    if (up) edit_m_d = (edit_m_q == M_LAST) ? '0 : edit_m_q + MW'(1);
                    else    edit_m_d = (edit_m_q == '0) ? M_LAST : edit_m_q - MW'(1);
                end
            end
            S_COMMIT: begin
                slot_h_d[sel_q] = edit_h_q;
                slot_m_d[sel_q] = edit_m_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_BOOT;
        endcase

        // Outputs are registered copies of what the next state presents.
        set_alarm_d   = 1'b0;
        set_index_d   = sel_d;
        set_hours_d   = edit_h_d;
        set_minutes_d = edit_m_d;
        editing_d     = 1'b0;
        edit_field_d  = 1'b0;
        boot_done_d   = 1'b1;
        if (state_q == S_BOOT) begin
            set_alarm_d   = 1'b1;
            set_index_d   = boot_cnt_q;
            set_hours_d   = DEF_H;
            set_minutes_d = DEF_M;
            boot_done_d   = 1'b0;
        end else begin
            case (state_d)
                S_IDLE: begin
                    set_hours_d   = slot_h_d[sel_d];
                    set_minutes_d = slot_m_d[sel_d];
                end
                S_EDIT_H: editing_d = 1'b1;
                S_EDIT_M: begin
                    editing_d    = 1'b1;
                    edit_field_d = 1'b1;
                end
                S_COMMIT: set_alarm_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            boot_cnt_q    <= '0;
            sel_q         <= '0;
            edit_h_q      <= DEF_H;
            edit_m_q      <= DEF_M;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                slot_h_q[k] <= DEF_H;
                slot_m_q[k] <= DEF_M;
            end
            set_alarm_q   <= 1'b0;
            set_index_q   <= '0;
            set_hours_q   <= DEF_H;
            set_minutes_q <= DEF_M;
            editing_q     <= 1'b0;
            edit_field_q  <= 1'b0;
            boot_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            sel_q         <= sel_d;
            edit_h_q      <= edit_h_d;
            edit_m_q      <= edit_m_d;
            slot_h_q      <= slot_h_d;
            slot_m_q      <= slot_m_d;
            set_alarm_q   <= set_alarm_d;
            set_index_q   <= set_index_d;
            set_hours_q   <= set_hours_d;
            set_minutes_q <= set_minutes_d;
            editing_q     <= editing_d;
            edit_field_q  <= edit_field_d;
            boot_done_q   <= boot_done_d;
        end
    end

    assign bus.set_alarm   = set_alarm_q;
    assign bus.set_index   = set_index_q;
    assign bus.set_hours   = set_hours_q;
    assign bus.set_minutes = set_minutes_q;
    assign bus.editing     = editing_q;
    assign bus.edit_field  = edit_field_q;
    assign bus.boot_done   = boot_done_q;
endmodule

// File: tb/tb_alarm_settings_ctrl.sv
// tb/tb_alarm_settings_ctrl.sv - vector table, directed corner sequences and randomized model check for alarm_settings_ctrl
module tb_alarm_settings_ctrl;
    localparam int N  = 2;
    localparam int HM = 24;
    localparam int MM = 60;
    localparam int DH = 2;
    localparam int DM = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alarm_settings_ctrl_if #(.IW(1), .HW(6), .MW(7)) bus ();

    alarm_settings_ctrl #(
        .NUM_ALARMS(N), .HOURS_MAX(HM), .MINUTES_MAX(MM),
        .DEF_HOURS(DH), .DEF_MINUTES(DM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    bit use_model = 1'b0;

    // Reference model: phase 0 boot, 1 idle, 2 edit hours, 3 edit minutes, 4 commit.
    int ph, cnt, sel, eh, em;
    int sh [N];
    int sm [N];
    int e_set, e_idx, e_h, e_m, e_ed, e_f, e_bd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int es, input int ei, input int h,
                             input int m, input int ee, input int ef, input int eb);
        chk({tag, ".set_alarm"},   int'(bus.set_alarm),   es);
        chk({tag, ".set_index"},   int'(bus.set_index),   ei);
        chk({tag, ".set_hours"},   int'(bus.set_hours),   h);
        chk({tag, ".set_minutes"}, int'(bus.set_minutes), m);
        chk({tag, ".editing"},     int'(bus.editing),     ee);
        chk({tag, ".edit_field"},  int'(bus.edit_field),  ef);
        chk({tag, ".boot_done"},   int'(bus.boot_done),   eb);
    endtask

    task automatic model_step(input bit r, input bit m, input bit i, input bit d, input bit s);
        if (r) begin
            ph = 0; cnt = 0; sel = 0; eh = DH; em = DM;
            for (int k = 0; k < N; k++) begin sh[k] = DH; sm[k] = DM; end
            e_set = 0; e_idx = 0; e_h = DH; e_m = DM; e_ed = 0; e_f = 0; e_bd = 0;
            return;
        end
        if (ph == 0) begin
            e_set = 1; e_idx = cnt; e_h = DH; e_m = DM; e_ed = 0; e_f = 0; e_bd = 0;
            cnt++;
            if (cnt == N) ph = 1;
            return;
        end
        case (ph)
            1: if (s) sel = (sel + 1) % N;
               else if (m) begin eh = sh[sel]; em = sm[sel]; ph = 2; end
            2: if (s) ph = 1;
               else if (m) ph = 3;
               else if (i != d) eh = i ? (eh + 1) % HM : (eh + HM - 1) % HM;
            3: if (s) ph = 1;
               else if (m) ph = 4;
               else if (i != d) em = i ? (em + 1) % MM : (em + MM - 1) % MM;
            default: begin sh[sel] = eh; sm[sel] = em; ph = 1; end
        endcase
        e_bd = 1; e_idx = sel; e_set = (ph == 4) ? 1 : 0;
        e_ed = (ph == 2 || ph == 3) ? 1 : 0;
        e_f  = (ph == 3) ? 1 : 0;
        if (ph == 1) begin e_h = sh[sel]; e_m = sm[sel]; end
        else begin e_h = eh; e_m = em; end
    endtask

    task automatic step(input bit r, input bit m, input bit i, input bit d, input bit s);
        rst = r; bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d; bus.btn_sel = s;
        @(posedge clk);
        #1;
        model_step(r, m, i, d, s);
        if (use_model) check_all("model", e_set, e_idx, e_h, e_m, e_ed, e_f, e_bd);
    endtask

    typedef struct {
        bit r, m, i, d, s;
        int es, ei, eh, em, ee, ef, eb;
        string name;
    } vec_t;
    vec_t vq [$];

    task automatic add(input string nm, input bit r, input bit m, input bit i, input bit d,
                       input bit s, input int es, input int ei, input int h, input int mm,
                       input int ee, input int ef, input int eb);
        vec_t v;
        v.name = nm; v.r = r; v.m = m; v.i = i; v.d = d; v.s = s;
        v.es = es; v.ei = ei; v.eh = h; v.em = mm; v.ee = ee; v.ef = ef; v.eb = eb;
        vq.push_back(v);
    endtask

    initial begin
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_sel = 1'b0;

        //   name          r  m  i  d  s   set idx  h   m  ed  f  bd
        add("reset0",      1, 0, 0, 0, 0,  0,  0,   2, 40, 0, 0, 0);
        add("reset1",      1, 1, 1, 0, 1,  0,  0,   2, 40, 0, 0, 0);
        add("boot0",       0, 1, 0, 0, 1,  1,  0,   2, 40, 0, 0, 0);
        add("boot1",       0, 1, 1, 0, 0,  1,  1,   2, 40, 0, 0, 0);
        add("boot_done",   0, 0, 0, 0, 0,  0,  0,   2, 40, 0, 0, 1);
        add("enter_h",     0, 1, 0, 0, 0,  0,  0,   2, 40, 1, 0, 1);
        add("dec_h1",      0, 0, 0, 1, 0,  0,  0,   1, 40, 1, 0, 1);
        add("dec_h0",      0, 0, 0, 1, 0,  0,  0,   0, 40, 1, 0, 1);
        add("dec_hwrap",   0, 0, 0, 1, 0,  0,  0,  23, 40, 1, 0, 1);
        add("inc_hwrap",   0, 0, 1, 0, 0,  0,  0,   0, 40, 1, 0, 1);
        add("incdec_h",    0, 0, 1, 1, 0,  0,  0,   0, 40, 1, 0, 1);
        add("mode_inc",    0, 1, 1, 0, 0,  0,  0,   0, 40, 1, 1, 1);
        add("inc_m",       0, 0, 1, 0, 0,  0,  0,   0, 41, 1, 1, 1);
        add("incdec_m",    0, 0, 1, 1, 0,  0,  0,   0, 41, 1, 1, 1);
        add("cancel_m",    0, 0, 1, 0, 1,  0,  0,   2, 40, 0, 0, 1);
        add("idle_hold",   0, 0, 0, 0, 0,  0,  0,   2, 40, 0, 0, 1);
        add("reenter_h",   0, 1, 0, 0, 0,  0,  0,   2, 40, 1, 0, 1);
        add("sel_mode_h",  0, 1, 0, 0, 1,  0,  0,   2, 40, 0, 0, 1);

        foreach (vq[k]) begin
            step(vq[k].r, vq[k].m, vq[k].i, vq[k].d, vq[k].s);
            check_all(vq[k].name, vq[k].es, vq[k].ei, vq[k].eh, vq[k].em, vq[k].ee, vq[k].ef, vq[k].eb);
        end

        // Edit slot 1 to 5:59 and commit; slot 0 stays at the default.
        step(0, 0, 0, 0, 1); check_all("s36_sel",   0, 1, 2, 40, 0, 0, 1);
        step(0, 1, 0, 0, 0); check_all("s36_edit",  0, 1, 2, 40, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
        check_all("s36_inc3", 0, 1, 5, 40, 1, 0, 1);
        step(0, 1, 0, 0, 0); check_all("s36_field", 0, 1, 5, 40, 1, 1, 1);
        for (int k = 0; k < 41; k++) step(0, 0, 0, 1, 0);
        check_all("s36_dec41", 0, 1, 5, 59, 1, 1, 1);
        step(0, 1, 0, 0, 0); check_all("s36_commit", 1, 1, 5, 59, 0, 0, 1);
        step(0, 1, 1, 0, 1); check_all("s36_ignore", 0, 1, 5, 59, 0, 0, 1);
        step(0, 0, 0, 0, 1); check_all("s36_slot0",  0, 0, 2, 40, 0, 0, 1);

        // Reset during minute edit throws everything back to the defaults.
        step(0, 0, 0, 0, 1); check_all("s40_slot1", 0, 1, 5, 59, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0); check_all("s40_mwrap", 0, 1, 5, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0); check_all("s40_rst",   0, 0, 2, 40, 0, 0, 0);
        step(0, 0, 0, 0, 0); check_all("s40_boot0", 1, 0, 2, 40, 0, 0, 0);
        step(0, 0, 0, 0, 0); check_all("s40_boot1", 1, 1, 2, 40, 0, 0, 0);
        step(0, 0, 0, 0, 0); check_all("s40_idle",  0, 0, 2, 40, 0, 0, 1);
        step(0, 0, 0, 0, 1); check_all("s40_slot1d", 0, 1, 2, 40, 0, 0, 1);

        use_model = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
